// File: rtl/osc_pkg.sv
// Shared constants for the multi-wave oscillator: wave selects, default duty
// and full-scale sample helpers.
package osc_pkg;

  typedef enum logic [1:0] {
    WAVE_PULSE  = 2'b00,
    WAVE_SAW    = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_SILENT = 2'b11
  } wave_e;

  localparam int unsigned DUTY_W       = 8;
  localparam logic [7:0]  DUTY_DEFAULT = 8'd128;

  // Largest positive value of a w-bit two's-complement sample.
  function automatic logic signed [31:0] sample_max(input int unsigned w);
    return $signed((32'd1 << (w - 32'd1)) - 32'd1);
  endfunction

  // Most negative value of a w-bit two's-complement sample.
  function automatic logic signed [31:0] sample_min(input int unsigned w);
    return -sample_max(w) - 32'sd1;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: counts 0..SAMPLE_DIV-1 and raises tick on the last count.
module sample_tick_gen #(
  parameter int unsigned CLK_FREQ    = 125_000_000,
  parameter int unsigned SAMPLE_RATE = 48000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned SAMPLE_DIV = CLK_FREQ / SAMPLE_RATE;
  localparam int unsigned CNT_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/multi_wave_osc.sv
// Phase-accumulator oscillator producing pulse, saw and (optionally) triangle samples.
// Triangle output is built only when MULTI_WAVE_OSC_TRIANGLE_EN is defined.
module multi_wave_osc
  import osc_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 125_000_000,
  parameter int unsigned SAMPLE_RATE = 48000,
  parameter int unsigned SAMPLE_W    = 16,
  parameter int unsigned PHASE_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [PHASE_W-1:0]         cfg_tuning,
  input  logic [1:0]                 cfg_wave,
  input  logic [DUTY_W-1:0]          cfg_duty,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid
);

  localparam logic signed [SAMPLE_W-1:0] S_MAX = SAMPLE_W'(sample_max(SAMPLE_W));
  localparam logic signed [SAMPLE_W-1:0] S_MIN = SAMPLE_W'(sample_min(SAMPLE_W));

  logic                       tick;
  logic                       pending;
  logic [PHASE_W-1:0]         phase;
  logic [PHASE_W-1:0]         act_tuning, sh_tuning;
  wave_e                      act_wave, sh_wave;
  logic [DUTY_W-1:0]          act_duty, sh_duty;
  logic signed [SAMPLE_W-1:0] wave_sample;

  sample_tick_gen #(
    .CLK_FREQ    (CLK_FREQ),
    .SAMPLE_RATE (SAMPLE_RATE)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // One-deep config slot; held low while reset is asserted.
  assign cfg_ready = ~pending & ~reset;

`ifdef MULTI_WAVE_OSC_TRIANGLE_EN
  logic [SAMPLE_W-1:0] tri_u, tri_rise;
  assign tri_u    = phase[PHASE_W-2 -: SAMPLE_W];
  assign tri_rise = {~tri_u[SAMPLE_W-1], tri_u[SAMPLE_W-2:0]};
`endif

  // Waveform shaping from the current phase and the active config.
  always_comb begin
    wave_sample = '0;
    case (act_wave)
      WAVE_PULSE: wave_sample = (phase[PHASE_W-1 -: DUTY_W] < act_duty) ? S_MAX : S_MIN;
      WAVE_SAW:   wave_sample = {~phase[PHASE_W-1], phase[PHASE_W-2 -: SAMPLE_W-1]};
`ifdef MULTI_WAVE_OSC_TRIANGLE_EN
      WAVE_TRI:   wave_sample = phase[PHASE_W-1] ? ~tri_rise : tri_rise;
`endif
      default:    wave_sample = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= 1'b0;
      phase        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      act_tuning   <= '0;
      act_wave     <= WAVE_PULSE;
      act_duty     <= DUTY_DEFAULT;
      sh_tuning    <= '0;
      sh_wave      <= WAVE_PULSE;
      sh_duty      <= DUTY_DEFAULT;
    end else begin
      sample_valid <= tick;
      if (cfg_valid && cfg_ready) begin
        sh_tuning <= cfg_tuning;
        sh_wave   <= wave_e'(cfg_wave);
        sh_duty   <= cfg_duty;
        pending   <= 1'b1;
      end
      // Sample and phase use the config in force before this tick.
      if (tick) begin
        if (enable) begin
          sample_out <= wave_sample;
          phase      <= phase + act_tuning;
        end else begin
          sample_out <= '0;
          phase      <= '0;
        end
        if (pending) begin
          act_tuning <= sh_tuning;
          act_wave   <= sh_wave;
          act_duty   <= sh_duty;
          pending    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_wave_osc.sv
// Scoreboard bench for multi_wave_osc: a reference model pushes expected samples
// at each tick, and a negedge monitor pops and compares them.
module tb_multi_wave_osc;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [31:0]        cfg_tuning;
  logic [1:0]         cfg_wave;
  logic [7:0]         cfg_duty;
  logic signed [15:0] sample_out;
  logic               sample_valid;

  int errors = 0;
  int checks = 0;

  multi_wave_osc #(
    .CLK_FREQ    (192000),
    .SAMPLE_RATE (48000),
    .SAMPLE_W    (16),
    .PHASE_W     (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_tuning   (cfg_tuning),
    .cfg_wave     (cfg_wave),
    .cfg_duty     (cfg_duty),
    .sample_out   (sample_out),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference waveform values computed arithmetically from the phase.
  function automatic int wave_exp(input logic [31:0] ph, input logic [1:0] wv,
                                  input logic [7:0] duty);
    int u;
    case (wv)
      2'd0: return (int'(ph >> 24) < int'(duty)) ? 32767 : -32768;
      2'd1: return int'(ph >> 16) - 32768;
`ifdef MULTI_WAVE_OSC_TRIANGLE_EN
      2'd2: begin
        u = int'((ph >> 15) & 32'h0000_FFFF);
        return ph[31] ? (32767 - u) : (u - 32768);
      end
`endif
      default: return 0;
    endcase
  endfunction

  // Reference model state
  int          exp_q[$];
  bit          started = 1'b0;
  bit          in_reset = 1'b0;
  int          m_cnt;
  logic [31:0] m_phase, m_tun, s_tun;
  logic [1:0]  m_wave, s_wave;
  logic [7:0]  m_duty, s_duty;
  bit          m_pend;

  always @(posedge clk) begin
    bit acc, tk;
    if (reset) begin
      m_cnt = 0; m_phase = '0; m_pend = 1'b0;
      m_tun = '0; m_wave = 2'd0; m_duty = 8'd128;
      s_tun = '0; s_wave = 2'd0; s_duty = 8'd128;
      exp_q.delete();
      started  = 1'b1;
      in_reset = 1'b1;
    end else begin
      in_reset = 1'b0;
      acc = cfg_valid && !m_pend;
      tk  = (m_cnt == 3);
      if (tk) begin
        exp_q.push_back(enable ? wave_exp(m_phase, m_wave, m_duty) : 0);
        m_phase = enable ? m_phase + m_tun : 32'd0;
        if (m_pend) begin
          m_tun = s_tun; m_wave = s_wave; m_duty = s_duty;
          m_pend = 1'b0;
        end
      end
      if (acc) begin
        s_tun = cfg_tuning; s_wave = cfg_wave; s_duty = cfg_duty;
        m_pend = 1'b1;
      end
      m_cnt = tk ? 0 : m_cnt + 1;
    end
  end

  // Output monitor
  always @(negedge clk) begin
    if (started) begin
      if (reset) begin
        if (in_reset) begin
          check("rst_sample", sample_out, 0);
          check("rst_valid", sample_valid, 0);
          check("rst_ready", cfg_ready, 0);
        end
      end else begin
        check("cfg_ready", cfg_ready, !m_pend);
        if (sample_valid) begin
          if (exp_q.size() == 0) check("spurious_valid", sample_valid, 0);
          else check("sample", sample_out, exp_q.pop_front());
        end else if (exp_q.size() != 0) begin
          check("missing_valid", sample_valid, 1);
          exp_q.delete();
        end
      end
    end
  end

  task automatic send_cfg(input logic [31:0] tun, input logic [1:0] wv, input logic [7:0] duty);
    bit rdy;
    bit done = 1'b0;
    cfg_valid = 1'b1; cfg_tuning = tun; cfg_wave = wv; cfg_duty = duty;
    for (int i = 0; i < 64 && !done; i++) begin
      rdy = cfg_ready;
      @(posedge clk); #1;
      done = rdy;
    end
    cfg_valid = 1'b0;
    if (!done) check("cfg_accept_timeout", done, 1);
  endtask

  task automatic wait_samples(input int n);
    int cnt = 0;
    for (int i = 0; i < n * 4 + 8 && cnt < n; i++) begin
      @(negedge clk);
      if (sample_valid) cnt++;
    end
    if (cnt < n) check("sample_timeout", cnt, n);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; cfg_valid = 1'b0;
    cfg_tuning = '0; cfg_wave = 2'd0; cfg_duty = 8'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", cfg_ready, 1);
    wait_samples(3);
    check("default_pulse", sample_out, 32767);

    // Pulse, saw, triangle at 1/16 cycle per sample
    @(posedge clk); #1;
    send_cfg(32'h1000_0000, 2'd0, 8'd128);
    wait_samples(20);
    send_cfg(32'h1000_0000, 2'd1, 8'd128);
    wait_samples(20);
    send_cfg(32'h1000_0000, 2'd2, 8'd128);
    wait_samples(20);

    // Boundaries: duty 0, silence, reverse-direction wrap
    send_cfg(32'h1000_0000, 2'd0, 8'd0);
    wait_samples(6);
    check("duty0_min", sample_out, -32768);
    send_cfg(32'h0800_0000, 2'd3, 8'd128);
    wait_samples(4);
    send_cfg(32'hF000_0000, 2'd1, 8'd200);
    wait_samples(6);

    // Back-to-back offers: second one stalls until the first is applied
    send_cfg(32'h1000_0000, 2'd1, 8'd128);
    check("ready_drop", cfg_ready, 0);
    send_cfg(32'h2000_0000, 2'd0, 8'd64);
    wait_samples(8);

    // Enable low then re-enable on a saw
    send_cfg(32'h1000_0000, 2'd1, 8'd128);
    wait_samples(3);
    @(posedge clk); #1 enable = 1'b0;
    wait_samples(2);
    check("enable_low_zero", sample_out, 0);
    @(posedge clk); #1 enable = 1'b1;
    wait_samples(1);
    check("reenable_phase0", sample_out, -32768);
    wait_samples(4);

    // Reset while a config is pending
    send_cfg(32'h3000_0000, 2'd1, 8'd10);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_midreset", cfg_ready, 1);
    wait_samples(3);
    check("defaults_after_reset", sample_out, 32767);

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/multi_wave_osc.md
MULTI_WAVE_OSC -- requirements
Module: multi_wave_osc

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 125_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter SAMPLE_RATE, default 48000, output sample rate in Hz.
REQ-003 SHALL have parameter SAMPLE_W, default 16, signed sample width.
REQ-004 SHALL have parameter PHASE_W, default 32, phase accumulator width, with PHASE_W >= SAMPLE_W+1.
REQ-005 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port enable  in  1  oscillator run; low forces silence and phase 0.
REQ-008 SHALL have port cfg_valid  in  1  config offer.
REQ-009 SHALL have port cfg_ready  out  1  config slot free.
REQ-010 SHALL have port cfg_tuning  in  PHASE_W  phase increment per sample.
REQ-011 SHALL have port cfg_wave  in  2  00 pulse, 01 saw, 10 triangle, 11 silence.
REQ-012 SHALL have port cfg_duty  in  8  pulse high threshold, compared against phase[PHASE_W-1:PHASE_W-8].
REQ-013 SHALL have port sample_out  out  SAMPLE_W  signed sample, held between updates.
REQ-014 SHALL have port sample_valid  out  1  one-cycle pulse when sample_out updates.

Function
REQ-015 SHALL derive SAMPLE_DIV = CLK_FREQ/SAMPLE_RATE; a counter runs 0..SAMPLE_DIV-1 and raises internal tick in the cycle it equals SAMPLE_DIV-1.
REQ-016 SHALL accept config on cfg_valid&&cfg_ready into a shadow register and set pending; cfg_ready = !pending.
REQ-017 SHALL, on tick with pending set, copy shadow to active config and clear pending; acceptance coinciding with a tick (pending was 0) is applied at the following tick.
REQ-018 SHALL, on tick, compute the sample from the current phase and the active config in force before that tick, registered so that sample_out and sample_valid change on the clock edge ending the tick cycle (latency 1).
REQ-019 SHALL, on tick with enable high, update phase <= phase + active tuning, modulo 2^PHASE_W (silent wrap), using the pre-tick tuning.
REQ-020 SHALL, on tick with enable low, output 0, set phase to 0, and still pulse sample_valid.
REQ-021 SHALL produce pulse: MAX = 2^(SAMPLE_W-1)-1 when phase top 8 bits < cfg_duty, else MIN = -2^(SAMPLE_W-1); duty 0 gives constant MIN, duty 128 gives 50%.
REQ-022 SHALL produce saw: phase[PHASE_W-1:PHASE_W-SAMPLE_W] with its MSB inverted, ramping MIN to MAX.
REQ-023 SHALL produce triangle: u = phase[PHASE_W-2:PHASE_W-SAMPLE_W-1]; rising value = u with MSB inverted when phase MSB=0, bitwise inverse of that rising value when phase MSB=1.
REQ-024 SHALL output 0 for wave 11.
REQ-025 SHALL NOT reset phase on config change; the waveform stays phase-continuous.

Reset
REQ-026 SHALL, on reset, clear sample_out, sample_valid, counter, phase and pending; active and shadow config become tuning 0, wave 00, duty 128.
REQ-027 SHALL hold cfg_ready low during reset and drive it high in the first cycle after.
REQ-028 SHALL discard a pending config on reset mid-operation.

Configuration
REQ-029 SHALL implement triangle only when macro MULTI_WAVE_OSC_TRIANGLE_EN is defined; without it, wave 10 outputs 0, as wave 11 does, and no triangle logic is synthesised.

Structure
REQ-030 SHALL place the wave-select constants, DUTY_DEFAULT=128 and the MAX/MIN sample constant helpers in shared package osc_pkg.
REQ-031 SHALL implement the divider as sub-module sample_tick_gen (params CLK_FREQ, SAMPLE_RATE; outputs tick).

Verification
(Params for all scenarios: CLK_FREQ=192000, SAMPLE_RATE=48000 so SAMPLE_DIV=4; SAMPLE_W=16, PHASE_W=32.)
REQ-032 SHALL cover pulse: tuning 0x1000_0000, wave 00, duty 128, enable=1 -> 8 samples 32767 then 8 samples -32768, repeating; sample_valid every 4 cycles.
REQ-033 SHALL cover saw: same tuning, wave 01 -> -32768, -28672, -24576 ... 28672, then wrap to -32768.
REQ-034 SHALL cover triangle (macro on): same tuning, wave 10 -> -32768, -24576, ... up to 32767, then descending; with macro off -> all 0.
REQ-035 SHALL cover handshake: offer config with cfg_valid held -> cfg_ready drops after acceptance, second offer stalls, new config takes effect exactly at the next tick, cfg_ready high again the cycle after that tick.
REQ-036 SHALL cover enable low mid-stream -> next sample 0 with valid pulse and phase 0; after re-enable, the first sample is the phase-0 value (-32768 for saw).
REQ-037 SHALL cover reset asserted with a config pending -> outputs 0, pending cleared, defaults active, cfg_ready high the first cycle after reset.
